// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-port target.
// The BMP180 values let a bench or board model mimic the sensor.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_ADDR     = 4'd1,
      ST_ACK_ADDR = 4'd2,
      ST_REG      = 4'd3,
      ST_ACK_REG  = 4'd4,
      ST_WRITE    = 4'd5,
      ST_ACK_WR   = 4'd6,
      ST_READ     = 4'd7,
      ST_MACK     = 4'd8
   } i2c_state_e;

   localparam logic [6:0] BMP180_ADDR     = 7'h77;
   localparam logic [7:0] BMP180_ID_REG   = 8'hD0;
   localparam logic [7:0] BMP180_ID       = 8'h55;
   localparam logic [7:0] BMP180_CTRL_REG = 8'hF4;
   localparam logic [7:0] BMP180_OUT_MSB  = 8'hF6;

endpackage

// File: rtl/i2c_line_sync.sv
// Pin synchronizer followed by a one-flop edge detector.
// Flops reset high so an idle bus never looks like an edge.
module i2c_line_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign lvl  = sync_q[STAGES-1];
   assign rise = lvl & ~prev_q;
   assign fall = ~lvl & prev_q;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with auto-incrementing register pointer and
// single-cycle read/write strobes toward a user register file.
module i2c_slave_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] ADDR        = BMP180_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] reg_addr,
   output logic [7:0] reg_wdata,
   output logic       reg_we,
   output logic       reg_re,
   input  logic [7:0] reg_rdata,
   output logic       busy,
   output logic [3:0] state
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start, stop;

   i2c_state_e state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] sh_q, sh_d;
   logic [7:0] ptr_q, ptr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       we_q, we_d;
   logic       re_q, re_d;
   logic       busy_q, busy_d;
   logic       oe_q, oe_d;
   logic       rw_q, rw_d;
   logic [7:0] byte_in;

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
      .clk  (clk),
      .reset(reset),
      .d    (scl),
      .lvl  (scl_lvl),
      .rise (scl_rise),
      .fall (scl_fall)
   );

   i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
      .clk  (clk),
      .reset(reset),
      .d    (sda),
      .lvl  (sda_lvl),
      .rise (sda_rise),
      .fall (sda_fall)
   );

   assign start = sda_fall & scl_lvl;
   assign stop  = sda_rise & scl_lvl;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sh_q    <= '0;
         ptr_q   <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         oe_q    <= 1'b0;
         rw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sh_q    <= sh_d;
         ptr_q   <= ptr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
         oe_q    <= oe_d;
         rw_q    <= rw_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sh_d    = sh_q;
      ptr_d   = ptr_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      re_d    = 1'b0;
      busy_d  = busy_q;
      oe_d    = oe_q;
      rw_d    = rw_q;
      byte_in = {sh_q[6:0], sda_lvl};
      // read data arrives the cycle after the fetch strobe
      if (re_q) sh_d = reg_rdata;
      if (start) begin
         state_d = ST_ADDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (stop) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         busy_d  = 1'b0;
      end else if (scl_rise) begin
         unique case (state_q)
            ST_ADDR: begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  if (byte_in[7:1] == ADDR) begin
                     state_d = ST_ACK_ADDR;
                     rw_d    = byte_in[0];
                     busy_d  = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end
            end
            ST_ACK_ADDR: begin
               cnt_d = '0;
               if (rw_q) begin
                  state_d = ST_READ;
                  re_d    = 1'b1;
               end else begin
                  state_d = ST_REG;
               end
            end
            ST_REG: begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  ptr_d   = byte_in;
                  state_d = ST_ACK_REG;
               end
            end
            ST_ACK_REG, ST_ACK_WR: begin
               cnt_d   = '0;
               state_d = ST_WRITE;
            end
            ST_WRITE: begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  wdata_d = byte_in;
                  we_d    = 1'b1;
                  state_d = ST_ACK_WR;
               end
            end
            ST_READ: begin
               sh_d  = {sh_q[6:0], 1'b0};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) state_d = ST_MACK;
            end
            ST_MACK: begin
               cnt_d = '0;
               if (!sda_lvl) begin
                  state_d = ST_READ;
                  ptr_d   = ptr_q + 8'd1;
                  re_d    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            default: ;
         endcase
      end else if (scl_fall) begin
         unique case (state_q)
            ST_ACK_ADDR, ST_ACK_REG: oe_d = 1'b1;
            ST_ACK_WR: begin
               oe_d  = 1'b1;
               ptr_d = ptr_q + 8'd1;
            end
            ST_READ: oe_d = ~sh_q[7];
            default: oe_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      reg_addr  = ptr_q;
      reg_wdata = wdata_q;
      reg_we    = we_q;
      reg_re    = re_q;
      busy      = busy_q;
      state     = state_q;
   end

   assign sda = oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master, register-file model and a
// strobe scoreboard checking reg_we/reg_re against expectations.
`timescale 1ns/1ps
module tb_i2c_slave_regs;
   import i2c_pkg::*;

   localparam time Q = 50ns;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   wire        sda;
   logic [7:0] reg_addr, reg_wdata, reg_rdata;
   logic       reg_we, reg_re, busy;
   logic [3:0] state;

   logic [7:0]  mem [256];
   logic [15:0] exp_we [$];
   logic [7:0]  exp_re [$];
   int n_cmp = 0;
   int n_bad = 0;
   int we_cnt = 0;
   int re_cnt = 0;
   int dut_low_cnt = 0;
   int busy_cnt = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   pullup (sda);
   assign sda = m_low ? 1'b0 : 1'bz;
   assign reg_rdata = mem[reg_addr];

   i2c_slave_regs #(.ADDR(BMP180_ADDR), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .scl      (scl),
      .sda      (sda),
      .reg_addr (reg_addr),
      .reg_wdata(reg_wdata),
      .reg_we   (reg_we),
      .reg_re   (reg_re),
      .reg_rdata(reg_rdata),
      .busy     (busy),
      .state    (state)
   );

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // scoreboard monitor for the strobes
   always @(negedge clk) begin
      logic [15:0] e;
      if (reg_we && reg_re) check("we_re_overlap", 16'd1, 16'd0);
      if (reg_we) begin
         we_cnt++;
         if (exp_we.size() == 0) begin
            check("we_unexpected", {reg_addr, reg_wdata}, 16'hxxxx);
         end else begin
            e = exp_we.pop_front();
            check("we_strobe", {reg_addr, reg_wdata}, e);
         end
         mem[reg_addr] = reg_wdata;
      end
      if (reg_re) begin
         re_cnt++;
         if (exp_re.size() == 0) begin
            check("re_unexpected", {8'h00, reg_addr}, 16'hxxxx);
         end else begin
            e = {8'h00, exp_re.pop_front()};
            check("re_strobe", {8'h00, reg_addr}, e);
         end
      end
      if (mon_en) begin
         if (sda === 1'b0 && !m_low) dut_low_cnt++;
         if (busy) busy_cnt++;
      end
   end

   task automatic send_bit(input bit b);
      m_low = ~b;
      #Q scl = 1'b1;
      #(2*Q) scl = 1'b0;
      #Q;
   endtask

   task automatic rd_bit(output bit b);
      m_low = 1'b0;
      #Q scl = 1'b1;
      #Q b = (sda !== 1'b0);
      #Q scl = 1'b0;
      #Q;
   endtask

   task automatic i2c_start();
      m_low = 1'b0;
      #Q scl = 1'b1;
      #Q m_low = 1'b1;
      #Q scl = 1'b0;
      #Q;
   endtask

   task automatic i2c_stop();
      m_low = 1'b1;
      #Q scl = 1'b1;
      #Q m_low = 1'b0;
      #Q;
   endtask

   task automatic wr_byte(input logic [7:0] v, output bit ack);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(input bit nack, output logic [7:0] v);
      bit b;
      for (int i = 0; i < 8; i++) begin
         rd_bit(b);
         v = {v[6:0], b};
      end
      send_bit(nack);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: sim time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit         a;
      logic [7:0] d;
      int         we0, re0;
      for (int i = 0; i < 256; i++) mem[i] = 8'(i + 8'h30);
      mem[8'h00] = 8'h00;
      mem[BMP180_ID_REG] = BMP180_ID;

      #35;
      check("rst_sda", {15'd0, sda === 1'b1}, 16'd1);
      check("rst_addr", {8'h00, reg_addr}, 16'h0000);
      check("rst_wdata", {8'h00, reg_wdata}, 16'h0000);
      check("rst_we_re", {14'd0, reg_we, reg_re}, 16'd0);
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_state", {12'd0, state}, {12'd0, ST_IDLE});
      reset = 1'b1;
      #100;

      // read the chip id
      exp_re.push_back(BMP180_ID_REG);
      i2c_start();
      wr_byte(8'hEE, a); check("id_ack_w", {15'd0, a}, 16'd0);
      wr_byte(8'hD0, a); check("id_ack_reg", {15'd0, a}, 16'd0);
      i2c_start();
      wr_byte(8'hEF, a); check("id_ack_r", {15'd0, a}, 16'd0);
      rd_byte(1'b1, d);  check("id_data", {8'h00, d}, 16'h0055);
      check("id_busy_on", {15'd0, busy}, 16'd1);
      i2c_stop();
      #100;
      check("id_busy_off", {15'd0, busy}, 16'd0);

      // write burst
      exp_we.push_back(16'hF42E);
      exp_we.push_back(16'hF534);
      i2c_start();
      wr_byte(8'hEE, a); check("wb_ack0", {15'd0, a}, 16'd0);
      wr_byte(8'hF4, a); check("wb_ack1", {15'd0, a}, 16'd0);
      wr_byte(8'h2E, a); check("wb_ack2", {15'd0, a}, 16'd0);
      wr_byte(8'h34, a); check("wb_ack3", {15'd0, a}, 16'd0);
      i2c_stop();
      #100;
      check("wb_ptr", {8'h00, reg_addr}, 16'h00F6);
      check("wb_count", 16'(we_cnt), 16'd2);

      // foreign address
      we0 = we_cnt; re0 = re_cnt;
      dut_low_cnt = 0; busy_cnt = 0; mon_en = 1'b1;
      i2c_start();
      wr_byte(8'hA0, a); check("mm_nack0", {15'd0, a}, 16'd1);
      wr_byte(8'h12, a); check("mm_nack1", {15'd0, a}, 16'd1);
      i2c_stop();
      #100;
      mon_en = 1'b0;
      check("mm_sda_low", 16'(dut_low_cnt), 16'd0);
      check("mm_busy", 16'(busy_cnt), 16'd0);
      check("mm_strobes", 16'(we_cnt - we0 + re_cnt - re0), 16'd0);

      // zero-data write just moves the pointer
      we0 = we_cnt;
      i2c_start();
      wr_byte(8'hEE, a); check("zw_ack0", {15'd0, a}, 16'd0);
      wr_byte(8'hF6, a); check("zw_ack1", {15'd0, a}, 16'd0);
      i2c_stop();
      #100;
      check("zw_ptr", {8'h00, reg_addr}, 16'h00F6);
      check("zw_no_we", 16'(we_cnt - we0), 16'd0);

      // park the pointer at 0xFF, then burst-read across the wrap
      i2c_start();
      wr_byte(8'hEE, a);
      wr_byte(8'hFF, a);
      i2c_stop();
      #100;
      check("wr_ptr_ff", {8'h00, reg_addr}, 16'h00FF);
      exp_re.push_back(8'hFF);
      exp_re.push_back(8'h00);
      exp_re.push_back(8'h01);
      i2c_start();
      wr_byte(8'hEF, a); check("wr_ack", {15'd0, a}, 16'd0);
      rd_byte(1'b0, d);  check("wr_d0", {8'h00, d}, 16'h002F);
      rd_byte(1'b0, d);  check("wr_d1", {8'h00, d}, 16'h0000);
      rd_byte(1'b1, d);  check("wr_d2", {8'h00, d}, 16'h0031);
      #50;
      check("wr_sda_rel", {15'd0, sda === 1'b1}, 16'd1);
      check("wr_state", {12'd0, state}, {12'd0, ST_IDLE});
      i2c_stop();
      #100;

      // reset in the middle of a read of register 0x00
      exp_re.push_back(8'h00);
      i2c_start();
      wr_byte(8'hEE, a);
      wr_byte(8'h00, a);
      i2c_start();
      wr_byte(8'hEF, a); check("rr_ack", {15'd0, a}, 16'd0);
      d = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         rd_bit(a);
         d = {d[6:0], a};
      end
      check("rr_nibble", {8'h00, d}, 16'h00F0);
      check("rr_sda_held", {15'd0, sda === 1'b0}, 16'd1);
      reset = 1'b0;
      #1;
      check("rr_sda_rel", {15'd0, sda === 1'b1}, 16'd1);
      check("rr_state", {12'd0, state}, {12'd0, ST_IDLE});
      #30 reset = 1'b1;
      #Q scl = 1'b1;
      #(4*Q);

      // full transaction after reset, then read it back
      exp_we.push_back(16'h10AB);
      i2c_start();
      wr_byte(8'hEE, a); check("rc_ack0", {15'd0, a}, 16'd0);
      wr_byte(8'h10, a); check("rc_ack1", {15'd0, a}, 16'd0);
      wr_byte(8'hAB, a); check("rc_ack2", {15'd0, a}, 16'd0);
      i2c_stop();
      #100;
      check("rc_ptr", {8'h00, reg_addr}, 16'h0011);
      exp_re.push_back(8'h10);
      i2c_start();
      wr_byte(8'hEE, a);
      wr_byte(8'h10, a);
      i2c_start();
      wr_byte(8'hEF, a);
      rd_byte(1'b1, d);  check("rc_data", {8'h00, d}, 16'h00AB);
      i2c_stop();
      #100;

      check("left_we", 16'(exp_we.size()), 16'd0);
      check("left_re", 16'(exp_re.size()), 16'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (slave) responder with a byte-wide register port. It is the far end of the bus driven by I2C_MASTER and acts as a BMP180 stand-in for bench and board loopback. It decodes START/STOP, matches a 7-bit address and maintains an auto-incrementing register pointer. Reads and writes are presented to user logic as single-cycle strobes, so a register file or sensor model can sit behind it.

## Interface
Parameters:
- ADDR, 7'h77, own 7-bit bus address (BMP180 default)
- SYNC_STAGES, 2, flip-flops in the scl/sda synchronizers (≥2)

Ports:
- clk  input  1  system clock; must be ≥16× SCL frequency
- reset  input  1  asynchronous, active-low reset
- scl  input  1  I2C clock, sampled only; no clock stretching
- sda  inout  1  I2C data, open-drain: driven 1'b0 or 1'bz, never 1
- reg_addr  output  8  current register pointer
- reg_wdata  output  8  byte received for write
- reg_we  output  1  one-cycle write strobe; reg_addr/reg_wdata valid in the same cycle
- reg_re  output  1  one-cycle fetch strobe; user logic must present reg_rdata on the next clk
- reg_rdata  input  8  read data for reg_addr
- busy  output  1  high from an addressed START to the next STOP/START
- state  output  4  current FSM state encoding, for debug pins

## Operation
- scl and sda pass through SYNC_STAGES flops, then a one-flop edge detector.
- START: sda falls while scl is high. STOP: sda rises while scl is high. Both are accepted in every state. A repeated START always goes to ADDR.
- Bits are sampled on the scl rising edge. sda is changed only on the scl falling edge.
- States and transitions:
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits, MSB first.
    - If [7:1]==ADDR → ACK_ADDR.
    - Otherwise → IDLE. sda stays released until the next START.
  - ACK_ADDR: drive ACK. Then go to READ if R/W=1, or to REG if R/W=0.
  - REG: byte loads reg_addr → ACK_REG → WRITE.
  - WRITE: byte → ACK_WR. reg_we pulses on the 8th rising edge with the current reg_addr. The pointer increments at the ACK falling edge.
  - READ: on entry, reg_re pulses and reg_rdata is latched into the shift register. Bits are driven MSB first; a 1 bit releases sda → MACK.
  - MACK: sample the master's bit.
    - 0 (ACK): pointer +1, reg_re pulses, → READ.
    - 1 (NACK): → IDLE, waiting for STOP/START.
- ACK is sda=0, held from the falling edge after bit 8 until the following falling edge.
- The pointer is 8-bit and wraps 0xFF → 0x00. A read with no preceding REG phase uses the retained pointer.
- STOP → IDLE, sda released, busy=0. The pointer is retained.
- A write with zero data bytes (REG then STOP) sets the pointer only; reg_we never pulses.

## Timing
- Reset values: sda=z, reg_addr=0x00, reg_wdata=0x00, reg_we=0, reg_re=0, busy=0, state=IDLE.
- Reset mid-transfer immediately releases sda and returns to IDLE.
- Input latency: an scl/sda edge is acted on SYNC_STAGES+1 clk after the pin changes.
- sda update: ≤SYNC_STAGES+2 clk after the scl falling edge at the pin. This is within the data hold time at clk ≥16×SCL.
- reg_rdata is latched exactly 1 clk after reg_re, and before the first data falling edge.
- reg_we and reg_re never assert in the same cycle.
- START/STOP take priority over bit processing in the same cycle.

## Structure
- Shared package i2c_pkg holds:
  - the state enum (4-bit)
  - BMP180_ADDR=7'h77, BMP180_ID_REG=8'hD0, BMP180_ID=8'h55, BMP180_CTRL_REG=8'hF4, BMP180_OUT_MSB=8'hF6
- Sub-module i2c_line_sync: synchronizer plus rise/fall detect. It is instantiated once for scl and once for sda.

## Test plan
- Read ID: bench holds reg_rdata=0x55 when reg_addr=0xD0. Master sends START, 0xEE, 0xD0, repeated START, 0xEF, then reads with NACK and STOP. Required: three ACKs, one reg_re pulse, byte 0x55 returned, busy falls after STOP.
- Write burst: START, 0xEE, 0xF4, 0x2E, 0x34, STOP. Required: reg_we pulses at (0xF4, 0x2E) and (0xF5, 0x34); final reg_addr=0xF6.
- Address mismatch: START, 0xA0, 0x12, STOP. Required: sda is never driven low, reg_we/reg_re stay 0, busy stays 0.
- Wrap-around read: pointer 0xFF, 3-byte read with ACK, ACK, NACK. Required: reg_re pulses at 0xFF, 0x00, 0x01; NACK ends the burst with sda released.
- Reset mid-byte: assert reset after 4 data bits of a read of 0x00. Required: sda goes to z within 1 clk, state=IDLE. The next full transaction succeeds.
- Zero-data write: START, 0xEE, 0xF6, STOP. Required: reg_addr=0xF6, no reg_we pulse.
